sram_like_slave: RTL

- Responder end of the in-order SRAM-like data interface driven by the execute stage (req/wr/size/addr/wdata in, addr_ok out).
- Completes each accepted request with a data_ok pulse and read data.
- Backed by an internal word-organised RAM, with programmable address and data latencies and a bounded outstanding-request queue.
- Used as the data-memory model in the CPU testbench, and as the front end for a later AXI bridge.

---
 rtl/sram_like_slave_pkg.sv | 33 +++
 rtl/sram_req_fifo.sv | 68 ++++++
 rtl/sram_like_slave.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sram_like_slave_pkg.sv
// Shared definitions for the SRAM-like data slave: size encodings, byte-lane
// helpers and the LFSR constants used by the SRAM_SLAVE_RAND_DELAY_EN build.
package sram_like_slave_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Enabled byte lanes; shifting in 4 bits clips halfword/word masks at lane 3.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] base;
        case (size)
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << a;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_req_fifo.sv
// Synchronous FIFO holding accepted-but-uncompleted requests; supports
// same-cycle push and pop. Caller must not push when full or pop when empty.
module sram_req_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 49,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_full;
    logic             r_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_count_nxt = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Full/empty registered from the next occupancy so they are clean flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/sram_like_slave.sv
// Responder for the in-order SRAM-like data interface, backed by a word RAM.
// Define SRAM_SLAVE_RAND_DELAY_EN to add LFSR-driven 0..3 cycle jitter to latencies.
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned ADDR_LAT  = 0,
    parameter int unsigned DATA_LAT  = 1,
    parameter int unsigned OST_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_addr_ok,
    output logic        o_data_ok,
    output logic [31:0] o_rdata
);

    localparam int unsigned ENT_W  = 1 + ADDR_W + 4 + 32;
    localparam int unsigned CNT_W  = $clog2(OST_DEPTH + 1);
    localparam int unsigned ACNT_W = $clog2(ADDR_LAT + 5);
    localparam int unsigned DCNT_W = $clog2(DATA_LAT + 5);
    localparam int unsigned WORDS  = 1 << ADDR_W;

    logic [1:0]        w_extra;
    logic [ACNT_W-1:0] r_acnt;
    logic [DCNT_W-1:0] r_dcnt;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [ENT_W-1:0]  w_push_data;
    logic [ENT_W-1:0]  w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_load_d;
    logic              w_head_wr;
    logic [ADDR_W-1:0] w_head_idx;
    logic [3:0]        w_head_lanes;
    logic [31:0]       w_head_wdata;
    logic              r_data_ok;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [WORDS];
    logic              w_unused;

`ifdef SRAM_SLAVE_RAND_DELAY_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= LFSR_SEED;
        else       r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 8'h00);
    end

    assign w_extra = r_lfsr[1:0];
`else
    assign w_extra = 2'b00;
`endif

    // Upper address bits alias onto the RAM.
    assign w_unused = &{1'b0, i_addr[31:ADDR_W+2]};

    assign w_push      = i_req & ~w_full & (r_acnt == '0);
    assign o_addr_ok   = w_push;
    assign w_push_data = {i_wr, i_addr[ADDR_W+1:2], lane_mask(i_size, i_addr[1:0]), i_wdata};
    assign {w_head_wr, w_head_idx, w_head_lanes, w_head_wdata} = w_head;
    assign w_pop       = ~w_empty & (r_dcnt == '0);

    // A new entry is head next cycle: push into an empty queue, or pop leaving one behind.
    assign w_load_d = w_push ? (w_empty | w_pop) : (w_pop & (w_count > CNT_W'(1)));

    sram_req_fifo #(
        .DEPTH (OST_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset)                r_acnt <= '0;
        else if (!i_req || w_push) r_acnt <= ACNT_W'(ADDR_LAT) + ACNT_W'(w_extra);
        else if (r_acnt != '0)    r_acnt <= r_acnt - ACNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)              r_dcnt <= '0;
        else if (w_load_d)      r_dcnt <= DCNT_W'(DATA_LAT) + DCNT_W'(w_extra);
        else if (r_dcnt != '0)  r_dcnt <= r_dcnt - DCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_data_ok <= w_pop;
            r_rdata   <= (w_pop && !w_head_wr) ? r_mem[w_head_idx] : '0;
        end
    end

    // Writes reach the RAM only when popped; a reset in that cycle drops them.
    always_ff @(posedge clk) begin
        if (!reset && w_pop && w_head_wr) begin
            r_mem[w_head_idx] <= lane_merge(r_mem[w_head_idx], w_head_wdata, w_head_lanes);
        end
    end

    assign o_data_ok = r_data_ok;
    assign o_rdata   = r_rdata;

endmodule
